instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction register.
- Owns the program counter and sequences reads from instruction memory using a request/acknowledge handshake.
- Delivers each fetched instruction byte with a one-cycle load strobe for the instruction register.
- Services jump and halt commands from the controller.

---
 rtl/instr_fetch_unit_pkg.sv | 11 +
 rtl/instr_fetch_unit_timeout_ctr.sv | 18 +
 rtl/instr_fetch_unit.sv | 118 +++++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: state encoding and default widths shared by the fetch, controller and PC logic.
package instr_fetch_unit_pkg;
  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;
  localparam int RESET_PC_DEF = 0;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_timeout_ctr.sv
// fetch_timeout_ctr: clear/enable wait counter whose terminal count marks the last allowed FETCH cycle.
module fetch_timeout_ctr #(
  parameter int WAIT_MAX = 15
) (
  input  logic clk,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [7:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  always_ff @(posedge clk) begin
    if (RST) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end
  assign tc = cnt_q == 8'(WAIT_MAX - 1);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, runs req/ack instruction fetches with timeout, services jump and halt.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int RESET_PC = RESET_PC_DEF,
  parameter int WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          fetch_en,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  input  logic          halt,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] instr,
  output logic          ir_load,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic          fetch_err
);
  fetch_state_e  state_q, state_d;
  logic [AW-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d, pending_addr_q, pending_addr_d;
  logic [DW-1:0] instr_q, instr_d;
  logic          ir_load_q, ir_load_d, fetch_err_q, fetch_err_d;
  logic          jump_pending_q, jump_pending_d;
  logic          tc, jump_hit;
  logic [AW-1:0] jump_tgt;

  fetch_timeout_ctr #(.WAIT_MAX(WAIT_MAX)) u_ctr (
    .clk (clk),
    .RST (RST),
    .clr (state_q != FETCH),
    .en  (state_q == FETCH),
    .tc  (tc)
  );

  // A jump arriving on the closing cycle of a fetch is the latest one, so it wins over any pending target.
  assign jump_hit = jump | jump_pending_q;
  assign jump_tgt = jump ? jump_addr : pending_addr_q;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    mem_addr_d     = mem_addr_q;
    pending_addr_d = pending_addr_q;
    jump_pending_d = jump_pending_q;
    instr_d        = instr_q;
    ir_load_d      = 1'b0;
    fetch_err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (halt) state_d = HALTED;
        else if (jump) pc_d = jump_addr;
        else if (fetch_en) begin
          state_d    = FETCH;
          mem_addr_d = pc_q;
        end
      end
      FETCH: begin
        if (halt) state_d = HALTED;
        else if (mem_ack) begin
          state_d        = IDLE;
          instr_d        = mem_data;
          ir_load_d      = 1'b1;
          pc_d           = jump_hit ? jump_tgt : pc_q + AW'(1);
          jump_pending_d = 1'b0;
        end else if (tc) begin
          state_d        = IDLE;
          fetch_err_d    = 1'b1;
          pc_d           = jump_hit ? jump_tgt : pc_q;
          jump_pending_d = 1'b0;
        end else if (jump) begin
          jump_pending_d = 1'b1;
          pending_addr_d = jump_addr;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q        <= IDLE;
      pc_q           <= AW'(RESET_PC);
      mem_addr_q     <= AW'(RESET_PC);
      pending_addr_q <= '0;
      jump_pending_q <= 1'b0;
      instr_q        <= '0;
      ir_load_q      <= 1'b0;
      fetch_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      mem_addr_q     <= mem_addr_d;
      pending_addr_q <= pending_addr_d;
      jump_pending_q <= jump_pending_d;
      instr_q        <= instr_d;
      ir_load_q      <= ir_load_d;
      fetch_err_q    <= fetch_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rd    = state_q == FETCH;
  assign busy      = state_q == FETCH;
  assign halted    = state_q == HALTED;
  assign instr     = instr_q;
  assign ir_load   = ir_load_q;
  assign pc        = pc_q;
  assign fetch_err = fetch_err_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed plus randomized fetch transactions checked against a transaction-level model.
module tb_instr_fetch_unit;
  localparam int WAIT_MAX = 15;
  logic       clk = 1'b0;
  logic       RST, fetch_en, jump, halt, mem_ack;
  logic [7:0] jump_addr, mem_data, mem_addr, instr, pc;
  logic       mem_rd, ir_load, busy, halted, fetch_err;
  int         n_cmp = 0, n_err = 0;
  logic [7:0] exp_pc, exp_instr;

  always #5 clk = ~clk;

  instr_fetch_unit #(.AW(8), .DW(8), .RESET_PC(0), .WAIT_MAX(WAIT_MAX)) dut (
    .clk       (clk),
    .RST       (RST),
    .fetch_en  (fetch_en),
    .jump      (jump),
    .jump_addr (jump_addr),
    .halt      (halt),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_ack   (mem_ack),
    .mem_data  (mem_data),
    .instr     (instr),
    .ir_load   (ir_load),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .fetch_err (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    fetch_en = 0; jump = 0; halt = 0; mem_ack = 0; jump_addr = 0; mem_data = 0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_pc", pc, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_instr", instr, 0);
    chk("rst_load", ir_load, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", fetch_err, 0);
  endtask

  task automatic reset_dut();
    idle_inputs();
    RST = 1;
    @(negedge clk);
    @(negedge clk);
    RST = 0;
    exp_pc = 0;
    exp_instr = 0;
    check_reset_outputs();
  endtask

  task automatic idle_jump(input logic [7:0] a);
    jump = 1; jump_addr = a; fetch_en = 1'($urandom);
    @(negedge clk);
    jump = 0; fetch_en = 0;
    exp_pc = a;
    chk("ijump_pc", pc, exp_pc);
    chk("ijump_no_rd", mem_rd, 0);
  endtask

  task automatic idle_ack();
    mem_ack = 1; mem_data = 8'($urandom);
    @(negedge clk);
    mem_ack = 0;
    chk("idle_ack_load", ir_load, 0);
    chk("idle_ack_instr", instr, exp_instr);
  endtask

  // w: wait states before ack (>= WAIT_MAX means never acked); jcyc: FETCH cycle carrying a jump, 0 = none
  task automatic fetch_txn(input int w, input int jcyc, input logic [7:0] ja, input logic [7:0] d);
    logic [7:0] a;
    bit jumped, acked;
    int c;
    a = exp_pc; jumped = 0; acked = 0; c = 0;
    fetch_en = 1;
    @(negedge clk);
    fetch_en = 0;
    while (!acked && c < WAIT_MAX) begin
      c++;
      chk("rd_held", mem_rd, 1);
      chk("busy_held", busy, 1);
      chk("addr_stable", mem_addr, a);
      chk("no_early_load", ir_load, 0);
      mem_ack = (c == w + 1);
      mem_data = mem_ack ? d : 8'($urandom);
      jump = (c == jcyc);
      jump_addr = jump ? ja : 8'($urandom);
      jumped |= jump;
      acked = mem_ack;
      @(negedge clk);
    end
    mem_ack = 0; jump = 0;
    if (acked) begin
      exp_instr = d;
      exp_pc = jumped ? ja : exp_pc + 8'd1;
    end else if (jumped) exp_pc = ja;
    chk("ir_load", ir_load, 32'(acked));
    chk("fetch_err", fetch_err, 32'(!acked));
    chk("instr", instr, exp_instr);
    chk("pc", pc, exp_pc);
    chk("rd_drop", mem_rd, 0);
    chk("busy_drop", busy, 0);
    @(negedge clk);
    chk("load_one_cycle", ir_load, 0);
    chk("err_one_cycle", fetch_err, 0);
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    @(negedge clk);
    reset_dut();
    fetch_txn(0, 0, 0, 8'hA5);
    reset_dut();
    fetch_txn(5, 0, 0, 8'h3C);
    reset_dut();
    jump = 1; jump_addr = 8'h40; fetch_en = 1;
    @(negedge clk);
    jump = 0; fetch_en = 0; exp_pc = 8'h40;
    chk("jump_fetch_pc", pc, 8'h40);
    chk("jump_fetch_no_rd", mem_rd, 0);
    fetch_txn(0, 0, 0, 8'h11);
    idle_jump(8'h10);
    fetch_txn(4, 2, 8'h80, 8'h5A);
    fetch_txn(WAIT_MAX + 5, 0, 0, 8'h00);
    fetch_txn(WAIT_MAX + 5, 7, 8'h22, 8'h00);
    fetch_txn(WAIT_MAX - 1, 0, 0, 8'h77);
    fetch_en = 1;
    @(negedge clk);
    fetch_en = 0;
    @(negedge clk);
    halt = 1; mem_ack = 1; mem_data = 8'hEE;
    @(negedge clk);
    halt = 0; mem_ack = 0;
    chk("halt_flag", halted, 1);
    chk("halt_rd", mem_rd, 0);
    chk("halt_load", ir_load, 0);
    chk("halt_pc", pc, exp_pc);
    for (int i = 0; i < 4; i++) begin
      fetch_en = 1; mem_ack = 1; jump = 1; jump_addr = 8'($urandom); mem_data = 8'($urandom);
      @(negedge clk);
      chk("halted_stays", halted, 1);
      chk("halted_no_rd", mem_rd, 0);
      chk("halted_no_load", ir_load, 0);
      chk("halted_pc", pc, exp_pc);
    end
    reset_dut();
    idle_jump(8'h33);
    fetch_en = 1;
    @(negedge clk);
    fetch_en = 0;
    @(negedge clk);
    RST = 1; mem_ack = 1; mem_data = 8'h99;
    @(negedge clk);
    RST = 0; mem_ack = 0;
    exp_pc = 0; exp_instr = 0;
    check_reset_outputs();
    idle_jump(8'hFF);
    fetch_txn(0, 0, 0, 8'hC3);
    chk("wrap_pc", pc, 8'h00);
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 5))
        0: idle_jump(8'($urandom));
        1: idle_ack();
        default: fetch_txn($urandom_range(0, WAIT_MAX + 3), $urandom_range(0, 8),
                           8'($urandom), 8'($urandom));
      endcase
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
